// File: rtl/fp16_pkg.sv
// fp16_pkg: definitions shared by the fp16 multiplier and adder.
//   - Class bit indices of the 6-bit one-hot class tag and the matching
//     one-hot constants.
//   - Exponent bias, canonical quiet NaN, and the binary16 field layout.
//   - lzc22: leading-zero count of a 22-bit significand product.
package fp16_pkg;

  localparam int unsigned FP_NORM = 5;
  localparam int unsigned FP_SUB  = 4;
  localparam int unsigned FP_ZERO = 3;
  localparam int unsigned FP_INF  = 2;
  localparam int unsigned FP_QNAN = 1;
  localparam int unsigned FP_SNAN = 0;

  localparam logic [5:0] CLS_NORM = 6'(1) << FP_NORM;
  localparam logic [5:0] CLS_SUB  = 6'(1) << FP_SUB;
  localparam logic [5:0] CLS_ZERO = 6'(1) << FP_ZERO;
  localparam logic [5:0] CLS_INF  = 6'(1) << FP_INF;
  localparam logic [5:0] CLS_QNAN = 6'(1) << FP_QNAN;

  localparam int unsigned BIAS = 15;
  localparam logic [15:0] QNAN = 16'h7E00;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;

  // Returns 22 for an all-zero input.
  function automatic logic [4:0] lzc22(input logic [21:0] v);
    logic [4:0] n;
    n = 5'd22;
    for (int unsigned i = 0; i < 22; i++) begin
      if (v[i]) n = 5'(21 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// fp16_round_pack: combinational round-to-nearest-even and pack stage.
//   sign  : result sign
//   exp   : biased exponent, 0 means subnormal (hidden bit is sig[10]=0)
//   sig   : 11-bit significand, sig[10] is the hidden bit for normals
//   grs   : {guard, round, sticky} bits below sig[0]
//   res   : packed binary16 result (overflow saturates to signed infinity)
//   cls   : one-hot class of res
module fp16_round_pack (
  input  logic        sign,
  input  logic [6:0]  exp,
  input  logic [10:0] sig,
  input  logic [2:0]  grs,
  output logic [15:0] res,
  output logic [5:0]  cls
);
  import fp16_pkg::*;

  logic        inc;
  logic [11:0] sum;
  logic [7:0]  exp_r;
  logic [9:0]  frac;

  always_comb begin
    inc   = grs[2] & (grs[1] | grs[0] | sig[0]);
    sum   = {1'b0, sig} + 12'(inc);
    // A carry out of the significand bumps the exponent; a subnormal that
    // rounds up into the hidden-bit position becomes the smallest normal.
    exp_r = {1'b0, exp} + 8'(sum[11]) + 8'((exp == 7'd0) & sum[10]);
    frac  = sum[11] ? sum[10:1] : sum[9:0];

    res = '0;
    cls = '0;
    if (exp_r >= 8'd31) begin
      res = {sign, 5'h1F, 10'h000};
      cls = CLS_INF;
    end else if (exp_r == 8'd0 && frac == 10'd0) begin
      res = {sign, 15'h0000};
      cls = CLS_ZERO;
    end else if (exp_r == 8'd0) begin
      res = {sign, 5'h00, frac};
      cls = CLS_SUB;
    end else begin
      res = {sign, exp_r[4:0], frac};
      cls = CLS_NORM;
    end
  end

endmodule

// File: rtl/mul.sv
// mul: pipelined IEEE-754 binary16 multiplier feeding the fp16 adder.
//   CLK      : clock, rising edge
//   RSTn     : asynchronous active-low reset
//   DVI      : input valid, one operation per cycle, no backpressure
//   DI_TYPE  : {b_type, a_type}, 6-bit one-hot class per operand (trusted)
//   DI       : {b, a} binary16 operands
//   DVO      : output valid, DVI delayed by LATENCY cycles
//   DO_TYPE  : one-hot class of DO
//   DO       : binary16 product, held while DVO is low
// Stages: 1 unpack/specials/multiply, 2 normalize/denormalize,
// 3 round/pack, then LATENCY-3 plain delay stages.
// Build option MUL_FTZ_EN: subnormal operands read as zero and subnormal
// results flush to signed zero; the denormalizing shifter is not built.
module mul #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        DVI,
  input  logic [11:0] DI_TYPE,
  input  logic [31:0] DI,
  output logic        DVO,
  output logic [5:0]  DO_TYPE,
  output logic [15:0] DO
);
  import fp16_pkg::*;

  localparam int unsigned NDLY = LATENCY - 2;

  // ---------------- stage 1 ----------------
  fp16_t       a, b;
  logic [5:0]  a_t, b_t;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        sp_nan, sp_inf, sp_zero;
  logic [15:0] sp_res;
  logic [5:0]  sp_type;
  logic        sgn;
  logic [10:0] sig_a, sig_b;
  logic [4:0]  exp_a, exp_b;
  logic [21:0] prod_c;
  logic signed [6:0] esum_c;

  assign a   = DI[15:0];
  assign b   = DI[31:16];
  assign a_t = DI_TYPE[5:0];
  assign b_t = DI_TYPE[11:6];

  always_comb begin
    a_nan  = a_t[FP_QNAN] | a_t[FP_SNAN];
    b_nan  = b_t[FP_QNAN] | b_t[FP_SNAN];
    a_inf  = a_t[FP_INF];
    b_inf  = b_t[FP_INF];
`ifdef MUL_FTZ_EN
    a_zero = a_t[FP_ZERO] | a_t[FP_SUB];
    b_zero = b_t[FP_ZERO] | b_t[FP_SUB];
`else
    a_zero = a_t[FP_ZERO];
    b_zero = b_t[FP_ZERO];
`endif
    sgn     = a.sign ^ b.sign;
    sp_nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    sp_inf  = ~sp_nan & (a_inf | b_inf);
    sp_zero = ~sp_nan & ~sp_inf & (a_zero | b_zero);

    sp_res  = '0;
    sp_type = '0;
    if (sp_nan) begin
      sp_res  = QNAN;
      sp_type = CLS_QNAN;
    end else if (sp_inf) begin
      sp_res  = {sgn, 5'h1F, 10'h000};
      sp_type = CLS_INF;
    end else if (sp_zero) begin
      sp_res  = {sgn, 15'h0000};
      sp_type = CLS_ZERO;
    end

    sig_a  = {a_t[FP_NORM], a.frac};
    sig_b  = {b_t[FP_NORM], b.frac};
    exp_a  = a_t[FP_SUB] ? 5'd1 : a.exp;
    exp_b  = b_t[FP_SUB] ? 5'd1 : b.exp;
    prod_c = 22'(sig_a) * 22'(sig_b);
    esum_c = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - $signed(7'(BIAS));
  end

  logic              s1_v;
  logic              s1_special;
  logic [15:0]       s1_sres;
  logic [5:0]        s1_stype;
  logic              s1_sign;
  logic [21:0]       s1_prod;
  logic signed [6:0] s1_exp;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s1_v       <= 1'b0;
      s1_special <= 1'b0;
      s1_sres    <= '0;
      s1_stype   <= '0;
      s1_sign    <= 1'b0;
      s1_prod    <= '0;
      s1_exp     <= '0;
    end else begin
      s1_v <= DVI;
      if (DVI) begin
        s1_special <= sp_nan | sp_inf | sp_zero;
        s1_sres    <= sp_res;
        s1_stype   <= sp_type;
        s1_sign    <= sgn;
        s1_prod    <= prod_c;
        s1_exp     <= esum_c;
      end
    end
  end

  // ---------------- stage 2 ----------------
  logic [4:0]        lz;
  logic [21:0]       norm;
  logic signed [7:0] exp_adj;
  logic [21:0]       sig_n;
  logic [6:0]        exp_n;
  logic              stk_n;
`ifndef MUL_FTZ_EN
  logic [7:0]        sh;
  logic [4:0]        sh_sat;
  logic [21:0]       sh_sig;
  logic [23:0]       lost;
`endif

  always_comb begin
    lz      = lzc22(s1_prod);
    norm    = s1_prod << lz;
    // Normalized product has its MSB at bit 21, one binade above the
    // product of two hidden bits, hence the +1.
    exp_adj = $signed({s1_exp[6], s1_exp}) + 8'sd1 - $signed({3'b000, lz});
    sig_n   = norm;
    exp_n   = exp_adj[6:0];
    stk_n   = 1'b0;
`ifdef MUL_FTZ_EN
    if (exp_adj < 8'sd1) begin
      sig_n = '0;
      exp_n = '0;
    end
`else
    sh     = 8'sd1 - exp_adj;
    sh_sat = (sh > 8'd24) ? 5'd24 : sh[4:0];
    {sh_sig, lost} = {norm, 24'h000000} >> sh_sat;
    if (exp_adj < 8'sd1) begin
      sig_n = sh_sig;
      exp_n = '0;
      stk_n = |lost;
    end
`endif
    if (s1_prod == '0) begin
      sig_n = '0;
      exp_n = '0;
      stk_n = 1'b0;
    end
  end

  logic        s2_v;
  logic        s2_special;
  logic [15:0] s2_sres;
  logic [5:0]  s2_stype;
  logic        s2_sign;
  logic [6:0]  s2_exp;
  logic [21:0] s2_sig;
  logic        s2_sticky;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s2_v       <= 1'b0;
      s2_special <= 1'b0;
      s2_sres    <= '0;
      s2_stype   <= '0;
      s2_sign    <= 1'b0;
      s2_exp     <= '0;
      s2_sig     <= '0;
      s2_sticky  <= 1'b0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_special <= s1_special;
        s2_sres    <= s1_sres;
        s2_stype   <= s1_stype;
        s2_sign    <= s1_sign;
        s2_exp     <= exp_n;
        s2_sig     <= sig_n;
        s2_sticky  <= stk_n;
      end
    end
  end

  // ---------------- stage 3 ----------------
  logic [15:0] rp_res, res3;
  logic [5:0]  rp_cls, cls3;

  fp16_round_pack u_round_pack (
    .sign (s2_sign),
    .exp  (s2_exp),
    .sig  (s2_sig[21:11]),
    .grs  ({s2_sig[10], s2_sig[9], (|s2_sig[8:0]) | s2_sticky}),
    .res  (rp_res),
    .cls  (rp_cls)
  );

  always_comb begin
    res3 = s2_special ? s2_sres  : rp_res;
    cls3 = s2_special ? s2_stype : rp_cls;
  end

  // Entry 0 is the stage-3 register; the rest are alignment delays.
  logic        dv [NDLY];
  logic [5:0]  dt [NDLY];
  logic [15:0] dd [NDLY];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int unsigned i = 0; i < NDLY; i++) begin
        dv[i] <= 1'b0;
        dt[i] <= '0;
        dd[i] <= '0;
      end
    end else begin
      dv[0] <= s2_v;
      if (s2_v) begin
        dt[0] <= cls3;
        dd[0] <= res3;
      end
      for (int unsigned i = 1; i < NDLY; i++) begin
        dv[i] <= dv[i-1];
        if (dv[i-1]) begin
          dt[i] <= dt[i-1];
          dd[i] <= dd[i-1];
        end
      end
    end
  end

  assign DVO     = dv[NDLY-1];
  assign DO_TYPE = dt[NDLY-1];
  assign DO      = dd[NDLY-1];

endmodule

// File: tb/tb_mul.sv
module tb_mul;
  localparam int LAT = 4;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        DVI;
  logic [11:0] DI_TYPE;
  logic [31:0] DI;
  logic        DVO;
  logic [5:0]  DO_TYPE;
  logic [15:0] DO;

  int checks = 0;
  int errors = 0;

  logic [21:0]    exp_q[$];
  logic [21:0]    last_exp = '0;
  logic [LAT-1:0] hist;

  mul #(.LATENCY(LAT)) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .DVI     (DVI),
    .DI_TYPE (DI_TYPE),
    .DI      (DI),
    .DVO     (DVO),
    .DO_TYPE (DO_TYPE),
    .DO      (DO)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  function automatic real pow2(input int k);
    real p;
    p = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) p = p * 2.0;
    else        for (int i = 0; i < -k; i++) p = p / 2.0;
    return p;
  endfunction

  function automatic logic [5:0] cls(input logic [15:0] x);
    if (x[14:10] == 5'h1F) begin
      if (x[9:0] == 10'd0) return 6'b000100;
      if (x[9])            return 6'b000010;
      return 6'b000001;
    end
    if (x[14:10] == 5'h00) return (x[9:0] == 10'd0) ? 6'b001000 : 6'b010000;
    return 6'b100000;
  endfunction

  function automatic real mag(input logic [15:0] x);
    if (x[14:10] == 5'h00) return real'(int'(x[9:0])) * pow2(-24);
    return real'(1024 + int'(x[9:0])) * pow2(int'(x[14:10]) - 25);
  endfunction

  function automatic int rne(input real n);
    int  r;
    real f;
    r = $rtoi(n);
    f = n - real'(r);
    if (f > 0.5 || (f == 0.5 && (r % 2) == 1)) r++;
    return r;
  endfunction

  function automatic logic [14:0] round_mag(input real v);
    int e, r;
    if (v < pow2(-14)) begin
      r = rne(v / pow2(-24));
      return 15'(r);
    end
    e = -14;
    while (v >= pow2(e + 1)) e++;
    r = rne(v / pow2(e - 10));
    if (r == 2048) begin
      r = 1024;
      e++;
    end
    if (e + 15 >= 31) return 15'h7C00;
    return 15'(((e + 15) << 10) | (r - 1024));
  endfunction

  // Returns {type, result}.
  function automatic logic [21:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [5:0]  ta, tb;
    logic        s;
    real         v;
    logic [15:0] r;
    ta = cls(a);
    tb = cls(b);
`ifdef MUL_FTZ_EN
    if (ta == 6'b010000) ta = 6'b001000;
    if (tb == 6'b010000) tb = 6'b001000;
`endif
    s = a[15] ^ b[15];
    if (ta[1] | ta[0] | tb[1] | tb[0] | (ta[2] & tb[3]) | (tb[2] & ta[3]))
      return {6'b000010, 16'h7E00};
    if (ta[2] | tb[2]) return {6'b000100, s, 15'h7C00};
    if (ta[3] | tb[3]) return {6'b001000, s, 15'h0000};
    v = mag(a) * mag(b);
`ifdef MUL_FTZ_EN
    if (v < pow2(-14)) return {6'b001000, s, 15'h0000};
`endif
    r = {s, round_mag(v)};
    return {cls(r), r};
  endfunction

  function automatic logic [15:0] rnd_op();
    logic [15:0] x;
    logic [15:0] sp [8];
    sp = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h7C01, 16'h0001, 16'h03FF};
    x = 16'($urandom);
    case ($urandom_range(0, 5))
      0: ;
      1: x[14:10] = 5'($urandom_range(0, 4));
      2: x[14:10] = 5'($urandom_range(10, 20));
      3: x[14:10] = 5'($urandom_range(24, 30));
      4: x[14:10] = 5'($urandom_range(1, 9));
      default: x = sp[$urandom_range(0, 7)];
    endcase
    return x;
  endfunction

  // ---------------- checking ----------------
  task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) hist <= '0;
    else       hist <= {hist[LAT-2:0], DVI};
  end

  always @(negedge CLK) begin : monitor
    logic [21:0] e;
    check16("dvo", {15'h0, DVO}, {15'h0, hist[LAT-1]});
    if (hist[LAT-1]) begin
      check16("queue_nonempty", {15'h0, exp_q.size() > 0}, 16'h0001);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        last_exp = e;
        check16("do", DO, e[15:0]);
        check16("do_type", {10'h0, DO_TYPE}, {10'h0, e[21:16]});
      end
    end else begin
      check16("do_hold", DO, last_exp[15:0]);
      check16("do_type_hold", {10'h0, DO_TYPE}, {10'h0, last_exp[21:16]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [15:0] a, input logic [15:0] b);
    @(negedge CLK);
    DVI     = 1'b1;
    DI      = {b, a};
    DI_TYPE = {cls(b), cls(a)};
    exp_q.push_back(model(a, b));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      DVI     = 1'b0;
      DI      = $urandom;
      DI_TYPE = 12'($urandom);
    end
  endtask

  initial begin
    RSTn    = 1'b1;
    DVI     = 1'b0;
    DI      = '0;
    DI_TYPE = '0;
    #1 RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    check16("reset_dvo", {15'h0, DVO}, 16'h0000);
    check16("reset_do", DO, 16'h0000);
    check16("reset_do_type", {10'h0, DO_TYPE}, 16'h0000);
    @(negedge CLK);
    #2 RSTn = 1'b1;

    // Basic product and latency
    drive(16'h3C00, 16'h4000);
    idle(LAT + 2);

    // Rounding and overflow
    drive(16'h3C01, 16'h3C01);
    drive(16'h7BFF, 16'h7BFF);
    drive(16'hFBFF, 16'h7BFF);
    idle(1);

    // Underflow
    drive(16'h0400, 16'h3800);
    drive(16'h0001, 16'h3800);
    drive(16'h0001, 16'h3C00);
    drive(16'h03FF, 16'h3C01);
    idle(2);

    // Specials
    drive(16'h7C00, 16'h8000);
    drive(16'h7C01, 16'h3C00);
    drive(16'hFC00, 16'h4000);
    drive(16'h8000, 16'h3C00);
    drive(16'h7E00, 16'h0000);
    idle(LAT + 1);

    // Streaming: 8 back-to-back, 2 idle, 3 more
    repeat (8) drive(rnd_op(), rnd_op());
    idle(2);
    repeat (3) drive(rnd_op(), rnd_op());
    idle(LAT + 1);

    // Reset mid-stream
    repeat (6) drive(rnd_op(), rnd_op());
    @(posedge CLK);
    #2;
    RSTn = 1'b0;
    DVI  = 1'b0;
    #1;
    check16("midreset_dvo", {15'h0, DVO}, 16'h0000);
    check16("midreset_do", DO, 16'h0000);
    check16("midreset_do_type", {10'h0, DO_TYPE}, 16'h0000);
    exp_q.delete();
    last_exp = '0;
    repeat (2) @(negedge CLK);
    #2 RSTn = 1'b1;
    idle(LAT + 2);

    // Random stream with random gaps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      drive(rnd_op(), rnd_op());
    end
    idle(LAT + 3);
    check16("drain_empty", 16'(exp_q.size()), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
